// File: rtl/circle_seg_animator.sv
// Purpose: walks a single lit segment around the outer ring (a..f) of a row of
//          7-segment displays, one ring position per prescaler overflow tick.
// Latency: the decoded outputs change one cycle after the overflow cycle.
//          overflow_o is a combinational decode of the registered count.
// Backpressure: none; the block free-runs, and only rst_ni can stall or restart it.
//
// Ports:
//   clk_i        rising-edge system clock
//   rst_ni       synchronous active-low reset; it overrides everything, even an overflow
//   count_o      prescaler value, counts 0..COUNT_TO
//   overflow_o   high for the single cycle in which count_o == COUNT_TO
//   directie     0 = clockwise lap, 1 = counter-clockwise lap
//   row          0 = lit segment in the top half (a, b, f), 1 = bottom half (c, d, e)
//   column       one-hot lit segment, bit0=a .. bit5=f
//   curr_display index of the display that holds the lit segment (0 = leftmost)

module circle_seg_animator #(
  parameter int WIDTH           = 4,
  parameter int COUNT_TO        = 9,
  parameter int NUM_OF_DISPLAYS = 6,
  parameter int COL_WIDTH       = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  output logic [WIDTH-1:0]     count_o,
  output logic                 overflow_o,
  output logic                 directie,
  output logic                 row,
  output logic [COL_WIDTH-1:0] column,
  output logic [2:0]           curr_display
);

  // Ring geometry. Positions run clockwise starting at segment a of display 0:
  // across the top row, down the right edge, back along the bottom row, and
  // up the left edge.
  localparam int RING_LEN = 2 * NUM_OF_DISPLAYS + 4;

  localparam logic [4:0] LAST_POS  = 5'(RING_LEN - 1);
  localparam logic [4:0] POS_B     = 5'(NUM_OF_DISPLAYS);          // right edge, upper
  localparam logic [4:0] POS_C     = 5'(NUM_OF_DISPLAYS + 1);      // right edge, lower
  localparam logic [4:0] POS_D_END = 5'(2 * NUM_OF_DISPLAYS + 1);  // last bottom-row slot
  localparam logic [4:0] POS_E     = 5'(2 * NUM_OF_DISPLAYS + 2);  // left edge, lower

  localparam logic [2:0] LAST_DISP = 3'(NUM_OF_DISPLAYS - 1);
  // The bottom row is walked right to left: display = (2N+1) - pos. Only the
  // low three bits of the difference matter because the result is always
  // below 8, so the subtraction can be done modulo 8 on pos[2:0].
  localparam logic [2:0] D_BASE    = 3'(2 * NUM_OF_DISPLAYS + 1);

  localparam logic [WIDTH-1:0] TERMINAL = WIDTH'(COUNT_TO);

  // Segment bit positions inside column.
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;

  logic [4:0] pos;
  logic [4:0] pos_inc;
  logic [4:0] pos_dec;
  logic [4:0] pos_step;

  // ---------------------------------------------------------------------------
  // Prescaler
  // ---------------------------------------------------------------------------
  assign overflow_o = (count_o == TERMINAL);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_o <= '0;
    end else if (overflow_o) begin
      count_o <= '0;
    end else begin
      count_o <= count_o + WIDTH'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Ring sequencer
  // ---------------------------------------------------------------------------
  assign pos_inc  = (pos == LAST_POS) ? 5'd0 : pos + 5'd1;
  assign pos_dec  = (pos == 5'd0) ? LAST_POS : pos - 5'd1;
  assign pos_step = directie ? pos_dec : pos_inc;

  // Arriving back at position 0 ends a lap. The direction flips on that same
  // edge, so successive laps alternate between clockwise and counter-clockwise.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pos      <= 5'd0;
      directie <= 1'b0;
    end else if (overflow_o) begin
      pos <= pos_step;
      if (pos_step == 5'd0) begin
        directie <= ~directie;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Position decode
  // ---------------------------------------------------------------------------
  always_comb begin
    column       = '0;
    curr_display = 3'd0;
    row          = 1'b0;
    if (pos < POS_B) begin
      curr_display  = pos[2:0];
      column[SEG_A] = 1'b1;
    end else if (pos == POS_B) begin
      curr_display  = LAST_DISP;
      column[SEG_B] = 1'b1;
    end else if (pos == POS_C) begin
      curr_display  = LAST_DISP;
      column[SEG_C] = 1'b1;
      row           = 1'b1;
    end else if (pos <= POS_D_END) begin
      curr_display  = D_BASE - pos[2:0];
      column[SEG_D] = 1'b1;
      row           = 1'b1;
    end else if (pos == POS_E) begin
      curr_display  = 3'd0;
      column[SEG_E] = 1'b1;
      row           = 1'b1;
    end else begin
      // The only position left is 2N+3, segment f of display 0. Positions
      // beyond the ring are never reached, so they fall through to here.
      curr_display  = 3'd0;
      column[SEG_F] = 1'b1;
    end
  end

endmodule

// File: tb/tb_circle_seg_animator.sv
module tb_circle_seg_animator;

  localparam int N = 6;
  localparam int L = 2 * N + 4;

  typedef struct packed {
    logic [2:0] disp;
    logic [5:0] col;
    logic       row;
    logic       dir;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] count;
  logic       ovf;
  logic       directie;
  logic       row;
  logic [5:0] column;
  logic [2:0] curr_display;

  logic [3:0] count15;
  logic       ovf15;
  logic       dir15;
  logic       row15;
  logic [5:0] col15;
  logic [2:0] disp15;

  int   errors = 0;
  int   checks = 0;
  exp_t ring [0:L-1];
  exp_t sb_q [$];
  int   m_pos;
  bit   m_dir;

  circle_seg_animator #(
    .WIDTH(4), .COUNT_TO(9), .NUM_OF_DISPLAYS(N), .COL_WIDTH(6)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .count_o(count), .overflow_o(ovf),
    .directie(directie), .row(row), .column(column), .curr_display(curr_display)
  );

  circle_seg_animator #(
    .WIDTH(4), .COUNT_TO(15), .NUM_OF_DISPLAYS(N), .COL_WIDTH(6)
  ) u_dut15 (
    .clk_i(clk), .rst_ni(rst_n), .count_o(count15), .overflow_o(ovf15),
    .directie(dir15), .row(row15), .column(col15), .curr_display(disp15)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Trace the ring geometrically: the top row left to right, down the right
  // edge, the bottom row right to left, then up the left edge.
  task automatic build_ring();
    int idx;
    idx = 0;
    for (int d = 0; d < N; d++) begin
      ring[idx] = {3'(d), 6'b000001, 1'b0, 1'b0}; idx++;
    end
    ring[idx] = {3'(N-1), 6'b000010, 1'b0, 1'b0}; idx++;
    ring[idx] = {3'(N-1), 6'b000100, 1'b1, 1'b0}; idx++;
    for (int d = N-1; d >= 0; d--) begin
      ring[idx] = {3'(d), 6'b001000, 1'b1, 1'b0}; idx++;
    end
    ring[idx] = {3'(0), 6'b010000, 1'b1, 1'b0}; idx++;
    ring[idx] = {3'(0), 6'b100000, 1'b0, 1'b0};
  endtask

  function automatic exp_t expect_of(int p, bit d);
    exp_t e;
    e     = ring[p];
    e.dir = d;
    return e;
  endfunction

  task automatic do_reset(int cycles);
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 rst_n = 1'b1;
    m_pos = 0;
    m_dir = 1'b0;
    sb_q.delete();
  endtask

  // Waits, for a bounded number of edges, until overflow is high. Called at #1 after an edge.
  task automatic wait_ovf(output int n);
    n = 0;
    while (!ovf && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ovf) begin
      errors++; checks++;
      $display("FAIL wait_ovf: no overflow within %0d cycles", n);
    end
  endtask

  // Waits for one tick, steps the model, pushes the expected decode, and
  // moves just past the stepping edge.
  task automatic advance_tick();
    int n;
    wait_ovf(n);
    if (m_dir == 1'b0) m_pos = (m_pos + 1) % L;
    else               m_pos = (m_pos + L - 1) % L;
    if (m_pos == 0) m_dir = ~m_dir;
    sb_q.push_back(expect_of(m_pos, m_dir));
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int n;
    do_reset(5);
    checks++;
    if ({count, curr_display, column, row, directie, ovf} !== {4'd0, 3'd0, 6'b000001, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: count=%0d disp=%0d col=%b row=%b dir=%b ovf=%b, need 0 0 000001 0 0 0",
               count, curr_display, column, row, directie, ovf);
    end
    wait_ovf(n);
    checks++;
    if (n !== 9) begin
      errors++; $display("FAIL first_ovf_delay: %0d cycles, need 9", n);
    end
    @(posedge clk); #1;
    checks++;
    if (ovf !== 1'b0 || count !== 4'd0) begin
      errors++; $display("FAIL ovf_width: ovf=%b count=%0d, need 0 0", ovf, count);
    end
    wait_ovf(n);
    checks++;
    if (n + 1 !== 10) begin
      errors++; $display("FAIL ovf_period: %0d cycles, need 10", n + 1);
    end
  endtask

  task automatic test_cw_walk();
    exp_t e;
    exp_t obs;
    do_reset(2);
    for (int t = 1; t <= 15; t++) begin
      advance_tick();
      e   = sb_q.pop_front();
      obs = {curr_display, column, row, directie};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL cw_tick%0d: disp=%0d col=%b row=%b dir=%b, need %0d %b %b %b",
                 t, obs.disp, obs.col, obs.row, obs.dir, e.disp, e.col, e.row, e.dir);
      end
      if (t == 6) begin
        checks++;
        if (curr_display !== 3'd5 || column !== 6'b000010 || row !== 1'b0) begin
          errors++; $display("FAIL cw_spot6: disp=%0d col=%b row=%b, need 5 000010 0", curr_display, column, row);
        end
      end
      if (t == 7) begin
        checks++;
        if (curr_display !== 3'd5 || column !== 6'b000100 || row !== 1'b1) begin
          errors++; $display("FAIL cw_spot7: disp=%0d col=%b row=%b, need 5 000100 1", curr_display, column, row);
        end
      end
      if (t == 13) begin
        checks++;
        if (curr_display !== 3'd0 || column !== 6'b001000 || row !== 1'b1) begin
          errors++; $display("FAIL cw_spot13: disp=%0d col=%b row=%b, need 0 001000 1", curr_display, column, row);
        end
      end
      if (t == 15) begin
        checks++;
        if (curr_display !== 3'd0 || column !== 6'b100000 || row !== 1'b0) begin
          errors++; $display("FAIL cw_spot15: disp=%0d col=%b row=%b, need 0 100000 0", curr_display, column, row);
        end
      end
    end
  endtask

  // Continues from tick 15 of the clockwise walk.
  task automatic test_lap_wrap();
    exp_t e;
    exp_t obs;
    for (int t = 16; t <= 32; t++) begin
      advance_tick();
      e   = sb_q.pop_front();
      obs = {curr_display, column, row, directie};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL lap_tick%0d: disp=%0d col=%b row=%b dir=%b, need %0d %b %b %b",
                 t, obs.disp, obs.col, obs.row, obs.dir, e.disp, e.col, e.row, e.dir);
      end
      if (t == 16) begin
        checks++;
        if (directie !== 1'b1 || column !== 6'b000001 || curr_display !== 3'd0) begin
          errors++; $display("FAIL lap_turn16: dir=%b col=%b disp=%0d, need 1 000001 0", directie, column, curr_display);
        end
      end
      if (t == 17) begin
        checks++;
        if (curr_display !== 3'd0 || column !== 6'b100000) begin
          errors++; $display("FAIL lap_back17: disp=%0d col=%b, need 0 100000", curr_display, column);
        end
      end
      if (t == 32) begin
        checks++;
        if (directie !== 1'b0 || column !== 6'b000001) begin
          errors++; $display("FAIL lap_turn32: dir=%b col=%b, need 0 000001", directie, column);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    exp_t obs;
    int   n;
    do_reset(2);
    // 16 ticks to finish a clockwise lap, then 7 counter-clockwise ticks down to position 9.
    for (int t = 1; t <= 23; t++) advance_tick();
    e   = sb_q.pop_back();
    sb_q.delete();
    obs = {curr_display, column, row, directie};
    checks++;
    if (obs !== e || obs !== {3'd4, 6'b001000, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL mid_pos9: disp=%0d col=%b row=%b dir=%b, need 4 001000 1 1", obs.disp, obs.col, obs.row, obs.dir);
    end
    wait_ovf(n);
    rst_n = 1'b0;           // reset lands on the same edge as the overflow
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_pos = 0; m_dir = 1'b0;
    checks++;
    if ({count, curr_display, column, row, directie} !== {4'd0, 3'd0, 6'b000001, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset: count=%0d disp=%0d col=%b row=%b dir=%b, need 0 0 000001 0 0",
               count, curr_display, column, row, directie);
    end
    wait_ovf(n);
    checks++;
    if (n !== 9) begin
      errors++; $display("FAIL mid_restart: first overflow after %0d cycles, need 9", n);
    end
  endtask

  task automatic test_prescaler_boundary();
    int c;
    int pulses;
    int exp_q [$];
    int e;
    do_reset(2);
    c = 0;
    pulses = 0;
    for (int i = 0; i < 48; i++) begin
      exp_q.push_back(c);
      e = exp_q.pop_front();
      checks++;
      if (count15 !== 4'(e) || ovf15 !== (e == 15)) begin
        errors++;
        $display("FAIL p15_cycle%0d: count=%0d ovf=%b, need %0d %b", i, count15, ovf15, e, (e == 15));
      end
      if (ovf15) pulses++;
      @(posedge clk); #1;
      c = (c + 1) % 16;
    end
    checks++;
    if (pulses !== 3) begin
      errors++; $display("FAIL p15_pulses: %0d pulses in 48 cycles, need 3", pulses);
    end
  endtask

  task automatic test_continuous();
    exp_t e;
    exp_t obs;
    int   bad_onehot;
    int   bad_disp;
    int   bad_sb;
    do_reset(2);
    bad_onehot = 0; bad_disp = 0; bad_sb = 0;
    for (int i = 0; i < 2000; i++) begin
      if (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        obs = {curr_display, column, row, directie};
        checks++;
        if (obs !== e) begin
          errors++; bad_sb++;
          if (bad_sb <= 5)
            $display("FAIL run_sb cycle%0d: disp=%0d col=%b row=%b dir=%b, need %0d %b %b %b",
                     i, obs.disp, obs.col, obs.row, obs.dir, e.disp, e.col, e.row, e.dir);
        end
      end
      checks++;
      if (!$onehot(column)) begin
        errors++; bad_onehot++;
        if (bad_onehot <= 5) $display("FAIL run_onehot cycle%0d: col=%b, need exactly one bit", i, column);
      end
      checks++;
      if (curr_display > 3'd5) begin
        errors++; bad_disp++;
        if (bad_disp <= 5) $display("FAIL run_disp cycle%0d: disp=%0d, need <= 5", i, curr_display);
      end
      if (ovf) begin
        if (m_dir == 1'b0) m_pos = (m_pos + 1) % L;
        else               m_pos = (m_pos + L - 1) % L;
        if (m_pos == 0) m_dir = ~m_dir;
        sb_q.push_back(expect_of(m_pos, m_dir));
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    m_pos = 0;
    m_dir = 1'b0;
    build_ring();
    test_reset();
    test_cw_walk();
    test_lap_wrap();
    test_reset_mid();
    test_prescaler_boundary();
    test_continuous();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/circle_seg_animator.md
Name: circle_seg_animator

Overview:
- Generates a single lit segment that circles the outer ring of a row of 7-segment displays.
- Contains two parts:
  - A free-running prescaler counter that emits a one-cycle overflow tick.
  - A ring sequencer that advances the lit segment by one position per tick.
  - The sequencer drives a display index, a one-hot outer-segment vector, a half flag and a direction flag.
- Sits between the board clock and the display multiplexer/segment pins.

Parameters:
- WIDTH, 4: prescaler counter width in bits.
- COUNT_TO, 9: terminal count; prescaler period is COUNT_TO+1 cycles. Must satisfy COUNT_TO ≤ 2^WIDTH−1.
- NUM_OF_DISPLAYS, 6: number of displays in the row. Range 2..8.
- COL_WIDTH, 6: width of the column (outer segment) vector. Fixed at 6 for segments a..f; g is unused.

Ports:
- clk_i, input, 1: single system clock; everything on the rising edge.
- rst_ni, input, 1: reset, synchronous, active-low.
- count_o, output, WIDTH: current prescaler value.
- overflow_o, output, 1: high for exactly the cycle in which count_o==COUNT_TO.
- directie, output, 1: ring direction. 0 = clockwise, 1 = counter-clockwise.
- row, output, 1: 0 when the lit segment is in the top half (a, b, f); 1 when in the bottom half (c, d, e).
- column, output, COL_WIDTH: one-hot lit segment. bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f.
- curr_display, output, 3: index of the display holding the lit segment. 0 = leftmost.

Behaviour:
- Reset (rst_ni==0 at a rising edge):
  - count_o=0, ring position pos=0, directie=0.
  - Decoded outputs after reset: curr_display=0, column=6'b000001, row=0, overflow_o=0.
  - Reset has priority over all other activity, including an overflow in the same cycle.
- Prescaler:
  - count_o increments by 1 on every edge.
  - When count_o==COUNT_TO, the next value is 0.
  - overflow_o is a combinational decode: (count_o==COUNT_TO).
  - In steady state the first overflow_o occurs COUNT_TO cycles after reset release, then every COUNT_TO+1 cycles.
- Ring length L = 2*NUM_OF_DISPLAYS+4. pos is an internal 5-bit register in range 0..L−1. With N=NUM_OF_DISPLAYS:
  - pos 0..N−1: segment a of display pos; row=0.
  - pos N: segment b of display N−1; row=0.
  - pos N+1: segment c of display N−1; row=1.
  - pos N+2..2N+1: segment d of display 2N+1−pos (right to left); row=1.
  - pos 2N+2: segment e of display 0; row=1.
  - pos 2N+3: segment f of display 0; row=0.
- Decoding: curr_display, column and row are combinational decodes of the registered pos, so they change one cycle after the overflow cycle.
- Stepping: on an edge with overflow_o==1:
  - directie==0: pos ← (pos+1) mod L.
  - directie==1: pos ← (pos−1) mod L, i.e. 0 goes to L−1.
  - If the new pos is 0, directie toggles on the same edge, so every completed lap reverses direction (ping-pong of laps).
  - No change to pos or directie on edges without overflow.
- Invariants: exactly one bit of column is ever set; curr_display is always < NUM_OF_DISPLAYS.
- Reset mid-lap: returns immediately to pos 0 and directie 0, and the prescaler restarts at 0.

Test Plan:
- Reset: hold rst_ni=0 for 5 cycles, then release → count_o=0, curr_display=0, column=000001, row=0, directie=0. First overflow_o pulse occurs 9 cycles after release, then every 10 cycles, each pulse 1 cycle wide.
- Clockwise walk (defaults, L=16):
  - After 6 ticks: pos 6 → curr_display=5, column=000010, row=0.
  - Tick 7: display 5, column=000100, row=1.
  - Tick 8: display 5, column=001000.
  - Tick 13: display 0, column=001000.
  - Tick 14: display 0, column=010000, row=1.
  - Tick 15: display 0, column=100000, row=0.
- Lap wrap: tick 16 → pos 0, directie=1. Tick 17 → pos 15 (display 0, column=100000). Tick 32 → pos 0, directie=0.
- Reset mid-operation: assert rst_ni=0 for 1 cycle at pos 9 with directie=1, coinciding with overflow_o=1 → pos=0, directie=0, count_o=0. No step is taken.
- Prescaler boundary: set COUNT_TO=15 with WIDTH=4 → count wraps 15→0, overflow every 16 cycles, with no spurious pulse.
- Continuous run of 2000 cycles: exactly one column bit high every cycle, and curr_display ≤ 5.
